// File: rtl/block_grid_engine_if.sv
// rtl/block_grid_engine_if.sv - control inputs and playfield outputs of the grid engine
interface block_grid_engine_if #(
    parameter int COLS  = 16,
    parameter int ROWS  = 16,
    parameter int CNT_W = 16
) ();
    logic                   move_l;
    logic                   move_r;
    logic                   fast_drop;
    logic [COLS*ROWS-1:0]   grid_out;
    logic [CNT_W-1:0]       lines_cleared;
    logic                   lock_pulse;
    logic                   game_over;

    modport master (
        output move_l, move_r, fast_drop,
        input  grid_out, lines_cleared, lock_pulse, game_over
    );

    modport slave (
        input  move_l, move_r, fast_drop,
        output grid_out, lines_cleared, lock_pulse, game_over
    );
endinterface

// File: rtl/block_grid_engine.sv
// rtl/block_grid_engine.sv - falling 1x1 block playfield with row clear and game-over detection
module block_grid_engine #(
    parameter int COLS      = 16,
    parameter int ROWS      = 16,
    parameter int TICK_DIV  = 25000000,
    parameter int FAST_DIV  = 3125000,
    parameter int SPAWN_COL = COLS / 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    block_grid_engine_if.slave bus
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int TW = $clog2(TICK_DIV) + 1;
    localparam logic [TW-1:0] TICK_LIM = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] FAST_LIM = TW'(FAST_DIV - 1);

    typedef enum logic [2:0] {S_FALL, S_LOCK, S_CLEAR, S_SPAWN, S_OVER} state_t;

    state_t          r_state;
    logic [ROWS-1:0] r_settled [COLS];
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic            r_valid;
    logic [RW-1:0]   r_scan;
    logic [TW-1:0]   r_tick_cnt;
    logic            r_prev_l;
    logic            r_prev_r;
    logic [CNT_W-1:0] r_lines;
    logic            r_lock_pulse;
    logic            r_game_over;

    logic                 w_edge_l, w_edge_r, w_tick;
    logic                 w_blocked, w_left_ok, w_right_ok, w_row_full;
    logic [TW-1:0]        w_limit;
    logic [ROWS-1:0]      w_shifted [COLS];
    logic [COLS*ROWS-1:0] w_grid;

    assign w_edge_l   = bus.move_l & ~r_prev_l;
    assign w_edge_r   = bus.move_r & ~r_prev_r;
    assign w_limit    = bus.fast_drop ? FAST_LIM : TICK_LIM;
    // ">=" also catches a counter left above the fast limit when fast_drop rises
    assign w_tick     = (r_tick_cnt >= w_limit);
    assign w_blocked  = (r_row == RW'(ROWS - 1)) || r_settled[r_col][r_row + RW'(1)];
    assign w_left_ok  = (r_col != '0) && !r_settled[r_col - CW'(1)][r_row];
    assign w_right_ok = (r_col != CW'(COLS - 1)) && !r_settled[r_col + CW'(1)][r_row];

    always_comb begin
        w_row_full = 1'b1;
        for (int c = 0; c < COLS; c++) w_row_full = w_row_full & r_settled[c][r_scan];
    end

    // Rows 0..scan move down one; row 0 refills empty, rows below scan untouched
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            for (int rr = 0; rr < ROWS; rr++) begin
                if (rr > int'(r_scan))  w_shifted[c][rr] = r_settled[c][rr];
                else if (rr == 0)       w_shifted[c][rr] = 1'b0;
                else                    w_shifted[c][rr] = r_settled[c][rr-1];
            end
        end
    end

    always_comb begin
        w_grid = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int rr = 0; rr < ROWS; rr++) begin
                w_grid[c*ROWS + rr] = r_settled[c][rr] |
                    (r_valid && (r_col == CW'(c)) && (r_row == RW'(rr)));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_FALL;
            for (int c = 0; c < COLS; c++) r_settled[c] <= '0;
            r_col        <= CW'(SPAWN_COL);
            r_row        <= '0;
            r_valid      <= 1'b1;
            r_scan       <= '0;
            r_tick_cnt   <= '0;
            r_prev_l     <= 1'b0;
            r_prev_r     <= 1'b0;
            r_lines      <= '0;
            r_lock_pulse <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_prev_l     <= bus.move_l;
            r_prev_r     <= bus.move_r;
            r_lock_pulse <= 1'b0;
            case (r_state)
                S_FALL: begin
                    if (w_tick) begin
                        r_tick_cnt <= '0;
                        if (w_blocked) r_state <= S_LOCK;
                        else           r_row   <= r_row + RW'(1);
                    end else begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                        if (w_edge_l && !w_edge_r && w_left_ok)
                            r_col <= r_col - CW'(1);
                        else if (w_edge_r && !w_edge_l && w_right_ok)
                            r_col <= r_col + CW'(1);
                    end
                end
                S_LOCK: begin
                    r_settled[r_col][r_row] <= 1'b1;
                    r_valid      <= 1'b0;
                    r_lock_pulse <= 1'b1;
                    r_scan       <= RW'(ROWS - 1);
                    r_state      <= S_CLEAR;
                end
                S_CLEAR: begin
                    if (w_row_full) begin
                        for (int c = 0; c < COLS; c++) r_settled[c] <= w_shifted[c];
                        r_lines <= r_lines + CNT_W'(1);
                    end else if (r_scan != '0) begin
                        r_scan <= r_scan - RW'(1);
                    end else begin
                        r_state <= S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    if (r_settled[SPAWN_COL][0]) begin
                        r_state     <= S_OVER;
                        r_game_over <= 1'b1;
                    end else begin
                        r_col      <= CW'(SPAWN_COL);
                        r_row      <= '0;
                        r_valid    <= 1'b1;
                        r_tick_cnt <= '0;
                        r_state    <= S_FALL;
                    end
                end
                S_OVER:  r_state <= S_OVER;
                default: r_state <= S_OVER;
            endcase
        end
    end

    assign bus.grid_out      = w_grid;
    assign bus.lines_cleared = r_lines;
    assign bus.lock_pulse    = r_lock_pulse;
    assign bus.game_over     = r_game_over;
endmodule

// File: tb/tb_block_grid_engine.sv
// tb/tb_block_grid_engine.sv - directed vectors and corner sequences for block_grid_engine
module tb_block_grid_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    block_grid_engine_if #(.COLS(4), .ROWS(4), .CNT_W(16)) bus ();

    block_grid_engine #(
        .COLS(4), .ROWS(4), .TICK_DIV(4), .FAST_DIV(2), .SPAWN_COL(2), .CNT_W(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic        ml;
        logic        mr;
        logic        fd;
        logic [15:0] grid;
        logic        lp;
    } vec_t;

    vec_t vt [27];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic ml, input logic mr, input logic fd);
        bus.move_l    = ml;
        bus.move_r    = mr;
        bus.fast_drop = fd;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // From a fresh spawn: move to target column, fall until lock, then advance post clocks
    task automatic drop(input int target, input int post);
        int k;
        for (int i = 0; i < ((target > 2) ? target - 2 : 2 - target); i++) begin
            set_in(target < 2, target > 2, 0);
            step(1);
            set_in(0, 0, 0);
            step(1);
        end
        k = 0;
        while (!bus.lock_pulse && k < 200) begin
            step(1);
            k++;
        end
        chk($sformatf("lock_seen_col%0d", target), {31'd0, bus.lock_pulse}, 32'd1);
        step(post);
    endtask

    initial begin
        int changes;
        logic [15:0] frozen;

        vt[0]  = '{0, 0, 0, 0, 16'h0100, 0};
        vt[1]  = '{4, 0, 0, 0, 16'h0200, 0};
        vt[2]  = '{4, 0, 0, 0, 16'h0400, 0};
        vt[3]  = '{4, 0, 0, 0, 16'h0800, 0};
        vt[4]  = '{4, 0, 0, 0, 16'h0800, 0};
        vt[5]  = '{1, 0, 0, 0, 16'h0800, 1};
        vt[6]  = '{1, 0, 0, 0, 16'h0800, 0};
        vt[7]  = '{4, 0, 0, 0, 16'h0900, 0};
        vt[8]  = '{1, 1, 0, 0, 16'h0810, 0};
        vt[9]  = '{1, 0, 0, 0, 16'h0810, 0};
        vt[10] = '{1, 1, 0, 0, 16'h0801, 0};
        vt[11] = '{1, 0, 0, 0, 16'h0802, 0};
        vt[12] = '{1, 1, 0, 0, 16'h0802, 0};
        vt[13] = '{10, 0, 1, 0, 16'h0880, 0};
        vt[14] = '{1, 0, 0, 0, 16'h0880, 0};
        vt[15] = '{1, 0, 0, 0, 16'h0880, 1};
        vt[16] = '{5, 0, 0, 0, 16'h0980, 0};
        vt[17] = '{1, 1, 1, 0, 16'h0980, 0};
        vt[18] = '{1, 0, 0, 0, 16'h0980, 0};
        vt[19] = '{1, 0, 0, 0, 16'h0980, 0};
        vt[20] = '{1, 0, 1, 0, 16'h0A80, 0};
        vt[21] = '{1, 0, 0, 0, 16'h0A80, 0};
        vt[22] = '{1, 0, 0, 1, 16'h0C80, 0};
        vt[23] = '{1, 0, 0, 1, 16'h0C80, 0};
        vt[24] = '{1, 0, 0, 1, 16'h0C80, 0};
        vt[25] = '{1, 0, 0, 0, 16'h0C80, 1};
        vt[26] = '{5, 0, 0, 0, 16'h0D80, 0};

        do_reset();
        chk("reset_lines", {16'd0, bus.lines_cleared}, 32'd0);
        chk("reset_game_over", {31'd0, bus.game_over}, 32'd0);
        for (int i = 0; i < 27; i++) begin
            set_in(vt[i].ml, vt[i].mr, vt[i].fd);
            step(vt[i].n);
            chk($sformatf("vec%0d_grid", i), {16'd0, bus.grid_out}, {16'd0, vt[i].grid});
            chk($sformatf("vec%0d_lock", i), {31'd0, bus.lock_pulse}, {31'd0, vt[i].lp});
        end
        chk("vec_lines", {16'd0, bus.lines_cleared}, 32'd0);

        // Line clear with a block above the full row shifting down
        do_reset();
        drop(0, 5);
        drop(0, 5);
        chk("stack_col0", {16'd0, bus.grid_out}, 32'h010C);
        drop(1, 5);
        drop(3, 5);
        chk("before_clear", {16'd0, bus.grid_out}, 32'h818C);
        drop(2, 6);
        chk("after_clear_grid", {16'd0, bus.grid_out}, 32'h0108);
        chk("after_clear_lines", {16'd0, bus.lines_cleared}, 32'd1);

        // Game over when spawn cell is occupied, then everything frozen
        do_reset();
        for (int i = 0; i < 4; i++) drop(2, 5);
        chk("over_flag", {31'd0, bus.game_over}, 32'd1);
        chk("over_grid", {16'd0, bus.grid_out}, 32'h0F00);
        frozen  = bus.grid_out;
        changes = 0;
        for (int i = 0; i < 100; i++) begin
            set_in(i[0], (i % 3) == 0, 1);
            step(1);
            if (bus.grid_out !== frozen || bus.lock_pulse !== 1'b0) changes++;
        end
        chk("over_frozen_changes", changes, 32'd0);
        chk("over_lines", {16'd0, bus.lines_cleared}, 32'd0);

        // Asynchronous reset in the middle of a row shift
        do_reset();
        drop(0, 5);
        drop(1, 5);
        drop(3, 5);
        drop(2, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("midclr_grid", {16'd0, bus.grid_out}, 32'h0100);
        chk("midclr_lines", {16'd0, bus.lines_cleared}, 32'd0);
        chk("midclr_over", {31'd0, bus.game_over}, 32'd0);
        chk("midclr_lock", {31'd0, bus.lock_pulse}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(4);
        chk("resume_fall", {16'd0, bus.grid_out}, 32'h0200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/block_grid_engine.md
Name: block_grid_engine

Overview:
Parametrised falling-block playfield engine: one 1x1 active block falls under a programmable gravity tick, moves left/right on button edges, and locks on contact. Full rows are cleared, rows above shift down, and cleared lines are counted. Game over is detected at spawn. Drives the packed playfield vector consumed by the display path.

Parameters:
COLS, 16, playfield width in columns
ROWS, 16, playfield height in rows (row 0 = top)
TICK_DIV, 25000000, clocks per gravity step at normal speed (>=2)
FAST_DIV, 3125000, clocks per gravity step while fast_drop high (>=2, <=TICK_DIV)
SPAWN_COL, COLS/2, spawn column
CNT_W, 16, width of lines_cleared

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
move_l  in  1  level; each rising edge requests a one-column move left
move_r  in  1  level; each rising edge requests a one-column move right
fast_drop  in  1  level; while high, gravity period = FAST_DIV
grid_out  out  COLS*ROWS  playfield; bit index = col*ROWS + row; value = settled OR active block
lines_cleared  out  CNT_W  total rows cleared since reset, wraps mod 2^CNT_W
lock_pulse  out  1  one-cycle pulse when the active block locks
game_over  out  1  sticky high after failed spawn

Behaviour:
- Reset (async, any state): settled = 0; active = (SPAWN_COL, 0), valid; state FALL; tick counter 0; edge registers for move_l/move_r cleared to 0; lines_cleared 0; lock_pulse 0; game_over 0. grid_out then has only bit SPAWN_COL*ROWS set.
- Edge detect: register the previous move_l/move_r values. A rising edge is input high and previous low. A held level produces one move only.
- Tick counter: increments each FALL cycle. A tick fires when counter == (fast_drop ? FAST_DIV : TICK_DIV) - 1, or when counter already exceeds that limit. The counter returns to 0 on a tick.
- FALL state:
  - Tick cycle: gravity only; any move edge in the same cycle is discarded. If row == ROWS-1 or settled[col][row+1] = 1, go to LOCK. Otherwise row <= row+1.
  - Non-tick cycle with move_l edge and no move_r edge: col <= col-1 if col > 0 and settled[col-1][row] = 0; otherwise no change.
  - Non-tick cycle with move_r edge and no move_l edge: col <= col+1 if col < COLS-1 and the target cell is empty.
  - Both edges in the same cycle: ignored.
- LOCK (1 cycle): settled[col][row] <= 1; active invalid; lock_pulse = 1; go to CLEAR with scan row r = ROWS-1.
- CLEAR (one row per cycle, bottom-up):
  - If row r is full (all COLS bits set): rows 0..r-1 shift down by one, row 0 becomes empty, lines_cleared++, and r stays the same so the shifted row is rechecked.
  - Otherwise, if r > 0, r <= r-1.
  - Otherwise (r = 0 checked), go to SPAWN. If row 0 was full, it is cleared, then the next cycle rechecks r = 0 (now empty) and goes to SPAWN.
- SPAWN (1 cycle): if settled[SPAWN_COL][0] = 1, go to OVER, game_over <= 1, active stays invalid. Otherwise active = (SPAWN_COL, 0), valid; tick counter 0; go to FALL.
- OVER: all inputs ignored; grid_out and lines_cleared frozen until reset.
- Moves are ignored in every state except FALL.
- Outputs are registered or derived from registers only; no combinational path from inputs to outputs.

Test Plan:
All scenarios use COLS=4, ROWS=4, TICK_DIV=4, FAST_DIV=2, SPAWN_COL=2.
1. Release reset, no inputs -> grid_out = 0x0100 (bit 8). Bit 9 after 4 clocks, bit 10 after 8, bit 11 after 12. LOCK on the 16th-clock tick, lock_pulse high 1 cycle, settled bit 11, then respawn at bit 8.
2. Three move_l edges on non-tick cycles -> col 1, then col 0, then clamped at col 0. move_l held high for 10 cycles -> exactly one move. move_l and move_r edges in the same cycle -> no move.
3. Move edge landing on a tick cycle -> discarded, block only descends. fast_drop high -> row advances every 2 clocks.
4. Drop blocks into cols 0,1,2,3 of row 3 -> after the 4th lock, row 3 is cleared, lines_cleared = 1, grid_out = only the new spawn bit 8. The bit pattern from rows above appears shifted down by one.
5. Stack col 2 to 4 blocks (rows 3..0 set) -> SPAWN finds bit 8 set: game_over = 1. Further move edges and ticks leave grid_out unchanged for 100 cycles.
6. Assert reset mid-CLEAR (during the row shift) -> same cycle: grid_out = 0x0100, lines_cleared = 0, game_over = 0, lock_pulse = 0. Normal fall resumes after deassertion.
